// File: rtl/fx2fp_pkg.sv
// Shared constants and types for the fixed-point to IEEE-754 single converter.
package fx2fp_pkg;

  localparam int FP32_EXP_W  = 8;
  localparam int FP32_MANT_W = 23;
  localparam int FP32_BIAS   = 127;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_MANT_W-1:0] mant;
  } fp32_t;

  localparam logic RND_TRUNC = 1'b0;
  localparam logic RND_RNE   = 1'b1;

endpackage

// File: rtl/lzd_n.sv
// Combinational leading-one detector: position of the highest set bit plus an all-zero flag.
module lzd_n #(
  parameter  int W  = 32,
  localparam int PW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  din,
  output logic [PW-1:0] pos,
  output logic          all_zero
);

  // NOTE: every variable driven from always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pos = '0;
    for (int i = 0; i < W; i++) begin
      if (din[i]) pos = PW'(i);
    end
  end

  assign all_zero = ~|din;

endmodule

// File: rtl/fixed_to_float32_pipe.sv
// Three-stage signed fixed-point to IEEE-754 single converter with valid/ready and global stall.
module fixed_to_float32_pipe
  import fx2fp_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter int FRAC_W = 30
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_rnd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data
);

  localparam int POS_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  if (IN_W < 2 || IN_W > 64 || FRAC_W < 0 || FRAC_W > IN_W - 1) begin : g_bad_params
    $error("fixed_to_float32_pipe: IN_W/FRAC_W outside the supported range");
  end

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Stage 1: sign / magnitude split
  logic            s1_valid, s1_sign, s1_zero, s1_rnd;
  logic [IN_W-1:0] s1_mag;
  logic [IN_W-1:0] mag_in;

  // Unsigned negation maps -2^(IN_W-1) onto 2^(IN_W-1) without overflow.
  assign mag_in = in_data[IN_W-1] ? (-in_data) : in_data;

  // Stage 2: normalisation
  logic             s2_valid, s2_sign, s2_zero, s2_rnd;
  logic [IN_W-2:0]  s2_frac;
  logic [7:0]       s2_exp;
  logic [POS_W-1:0] lzd_pos, shamt;
  logic             lzd_zero;
  logic [IN_W-2:0]  frac_shifted;
  logic [7:0]       exp_calc;

  lzd_n #(.W(IN_W)) u_lzd (
    .din      (s1_mag),
    .pos      (lzd_pos),
    .all_zero (lzd_zero)
  );

  // The leading one itself shifts out of the top, leaving only the bits below it.
  assign shamt        = POS_W'(IN_W - 1) - lzd_pos;
  assign frac_shifted = s1_mag[IN_W-2:0] << shamt;
  assign exp_calc     = 8'(lzd_pos) + 8'(FP32_BIAS) - 8'(FRAC_W);

  // Stage 3: mantissa extraction, rounding and packing
  logic [IN_W+22:0] frac_ext;
  logic [22:0]      mant_raw;
  logic             guard, sticky, round_inc;
  logic [23:0]      mant_sum;
  fp32_t            result;

  assign frac_ext  = {s2_frac, 24'b0};
  assign mant_raw  = frac_ext[IN_W+22 -: 23];
  assign guard     = frac_ext[IN_W-1];
  assign sticky    = |frac_ext[IN_W-2:0];
  assign round_inc = (s2_rnd == RND_RNE) && guard && (sticky || mant_raw[0]);
  assign mant_sum  = {1'b0, mant_raw} + {23'b0, round_inc};

  always_comb begin
    result.sign = s2_sign;
    result.exp  = s2_exp + {7'b0, mant_sum[23]};
    result.mant = mant_sum[22:0];
    if (s2_zero) result = '0;
  end

  // NOTE: state registers use non-blocking assignments so every stage samples the previous stage's pre-edge value.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_zero   <= 1'b0;
      s1_rnd    <= RND_TRUNC;
      s1_mag    <= '0;
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_zero   <= 1'b0;
      s2_rnd    <= RND_TRUNC;
      s2_frac   <= '0;
      s2_exp    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      s1_sign   <= in_data[IN_W-1];
      s1_zero   <= ~|in_data;
      s1_rnd    <= in_rnd;
      s1_mag    <= mag_in;

      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_zero   <= s1_zero | lzd_zero;
      s2_rnd    <= s1_rnd;
      s2_frac   <= frac_shifted;
      s2_exp    <= exp_calc;

      out_valid <= s2_valid;
      if (s2_valid) out_data <= result;
    end
  end

endmodule
